// File: rtl/cnt_onehot_updn_n_pkg.sv
// Shared definitions for the one-hot up/down counter: direction encodings,
// the per-cycle action decode and the index-width helper.
package cnt_onehot_updn_n_pkg;

  // Direction encodings for the inc input.
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // What the counter does on a given cycle, once reset is excluded.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_STEP,
    ACT_LOAD,
    ACT_RECOVER
  } act_e;

  // Ceiling log2 with a minimum of 1, so an index port always has a bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/cnt_onehot_updn_n_onehot2bin.sv
// One-hot to binary encoder with a validity flag (exactly one bit set).
// Drives both the binary index output and illegal-state detection.
module onehot2bin #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  onehot,
  output logic [IW-1:0] bin,
  output logic          valid
);

  logic seen;
  logic multi;

  // Scan all bits: OR together the indices of set bits and flag 0 or >1 set.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no
    // path leaves it unassigned and no latch is inferred.
    bin   = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        bin  = bin | IW'(i);
      end
    end
    valid = seen & ~multi;
  end

endmodule

// File: rtl/cnt_onehot_updn_n.sv
// N-state one-hot up/down counter with enable, synchronous load, optional
// saturation at the end stops, binary index output and recovery from any
// illegal (non one-hot) register contents.
module cnt_onehot_updn_n
  import cnt_onehot_updn_n_pkg::*;
#(
  parameter int  N        = 5,
  parameter bit  SATURATE = 1'b0,
  localparam int IW       = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rb,
  input  logic          en,
  input  logic          inc,
  input  logic          load,
  input  logic [IW-1:0] load_idx,
  output logic [N-1:0]  cnt,
  output logic [IW-1:0] idx,
  output logic          wrap,
  output logic          sat,
  output logic          err
);

  localparam logic [N-1:0] STATE0 = N'(1);

  logic [N-1:0] cnt_q, cnt_d;
  logic         wrap_q, wrap_d;
  logic         sat_q, sat_d;
  logic         err_q, err_d;

  logic         cnt_valid;
  act_e         act;
  logic [N-1:0] rot_up;
  logic [N-1:0] rot_dn;
  logic         end_hit;

  // The single encoder serves both the index output and the legality check.
  onehot2bin #(
    .N  (N),
    .IW (IW)
  ) u_enc (
    .onehot (cnt_q),
    .bin    (idx),
    .valid  (cnt_valid)
  );

  // Pick this cycle's action: recovery beats load, load beats enable.
  always_comb begin
    act = ACT_HOLD;
    if (!cnt_valid)  act = ACT_RECOVER;
    else if (load)   act = ACT_LOAD;
    else if (en)     act = ACT_STEP;
  end

  // Next state from a rotate of the current one-hot vector; end stops masked
  // when saturating.
  always_comb begin
    rot_up  = {cnt_q[N-2:0], cnt_q[N-1]};
    rot_dn  = {cnt_q[0], cnt_q[N-1:1]};
    end_hit = (inc == DIR_UP) ? cnt_q[N-1] : cnt_q[0];

    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;

    unique case (act)
      ACT_RECOVER: begin
        cnt_d = STATE0;
        err_d = 1'b1;
      end
      ACT_LOAD: begin
        if (int'(load_idx) < N) begin
          cnt_d = STATE0 << load_idx;
        end else begin
          cnt_d = STATE0;
          err_d = 1'b1;
        end
      end
      ACT_STEP: begin
        if (end_hit && SATURATE) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d  = (inc == DIR_UP) ? rot_up : rot_dn;
          wrap_d = end_hit;
        end
      end
      default: cnt_d = cnt_q;
    endcase

    // Saturation level reflects the new state against the current direction.
    sat_d = SATURATE && ((inc == DIR_DN) ? cnt_d[0] : cnt_d[N-1]);
  end

  // State and flag registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rb) begin
      cnt_q  <= STATE0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
      err_q  <= err_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;
  assign sat  = sat_q;
  assign err  = err_q;

endmodule

// File: tb/tb_cnt_onehot_updn_n.sv
// Directed self-checking bench for cnt_onehot_updn_n: N=5 wrap, N=5 saturate
// and N=2 instances on one clock, each with its own stimulus.
module tb_cnt_onehot_updn_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N=5, wrapping
  logic       a_rb, a_en, a_inc, a_load;
  logic [2:0] a_load_idx, a_idx;
  logic [4:0] a_cnt;
  logic       a_wrap, a_sat, a_err;

  // N=5, saturating
  logic       s_rb, s_en, s_inc, s_load;
  logic [2:0] s_load_idx, s_idx;
  logic [4:0] s_cnt;
  logic       s_wrap, s_sat, s_err;

  // N=2, wrapping
  logic       b_rb, b_en, b_inc, b_load;
  logic [0:0] b_load_idx, b_idx;
  logic [1:0] b_cnt;
  logic       b_wrap, b_sat, b_err;

  cnt_onehot_updn_n #(.N(5), .SATURATE(1'b0)) u_d5 (
    .clk(clk), .rb(a_rb), .en(a_en), .inc(a_inc), .load(a_load),
    .load_idx(a_load_idx), .cnt(a_cnt), .idx(a_idx), .wrap(a_wrap),
    .sat(a_sat), .err(a_err)
  );

  cnt_onehot_updn_n #(.N(5), .SATURATE(1'b1)) u_s5 (
    .clk(clk), .rb(s_rb), .en(s_en), .inc(s_inc), .load(s_load),
    .load_idx(s_load_idx), .cnt(s_cnt), .idx(s_idx), .wrap(s_wrap),
    .sat(s_sat), .err(s_err)
  );

  cnt_onehot_updn_n #(.N(2), .SATURATE(1'b0)) u_d2 (
    .clk(clk), .rb(b_rb), .en(b_en), .inc(b_inc), .load(b_load),
    .load_idx(b_load_idx), .cnt(b_cnt), .idx(b_idx), .wrap(b_wrap),
    .sat(b_sat), .err(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [4:0] c, input logic [2:0] i,
                       input logic w, input logic e);
    check({tag, ".cnt"},  32'(a_cnt),  32'(c));
    check({tag, ".idx"},  32'(a_idx),  32'(i));
    check({tag, ".wrap"}, 32'(a_wrap), 32'(w));
    check({tag, ".err"},  32'(a_err),  32'(e));
  endtask

  task automatic chk_s(input string tag, input logic [4:0] c, input logic [2:0] i,
                       input logic w, input logic st);
    check({tag, ".cnt"},  32'(s_cnt),  32'(c));
    check({tag, ".idx"},  32'(s_idx),  32'(i));
    check({tag, ".wrap"}, 32'(s_wrap), 32'(w));
    check({tag, ".sat"},  32'(s_sat),  32'(st));
  endtask

  task automatic chk_b(input string tag, input logic [1:0] c, input logic i,
                       input logic w);
    check({tag, ".cnt"},  32'(b_cnt),  32'(c));
    check({tag, ".idx"},  32'(b_idx),  32'(i));
    check({tag, ".wrap"}, 32'(b_wrap), 32'(w));
  endtask

  // Hand-computed expectations for the directed sequences.
  logic [4:0] t1_cnt  [6] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00010};
  logic [2:0] t1_idx  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
  logic       t1_wrap [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  logic [4:0] t5_cnt  [7] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b10000, 5'b10000, 5'b10000};
  logic [2:0] t5_idx  [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
  logic       t5_sat  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    a_rb = 1'b1; a_en = 1'b0; a_inc = 1'b1; a_load = 1'b0; a_load_idx = '0;
    s_rb = 1'b1; s_en = 1'b0; s_inc = 1'b1; s_load = 1'b0; s_load_idx = '0;
    b_rb = 1'b1; b_en = 1'b0; b_inc = 1'b1; b_load = 1'b0; b_load_idx = '0;
    tick();
    tick();

    // Reset state on all instances
    chk_a("rst_a", 5'b00001, 3'd0, 1'b0, 1'b0);
    check("rst_a.sat", 32'(a_sat), 32'd0);
    chk_s("rst_s", 5'b00001, 3'd0, 1'b0, 1'b0);
    check("rst_s.err", 32'(s_err), 32'd0);
    chk_b("rst_b", 2'b01, 1'b0, 1'b0);
    check("rst_b.err", 32'(b_err), 32'd0);
    a_rb = 1'b0; s_rb = 1'b0; b_rb = 1'b0;

    // 1: count up through a wrap
    a_en = 1'b1; a_inc = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_a($sformatf("up%0d", k), t1_cnt[k], t1_idx[k], t1_wrap[k], 1'b0);
    end
    a_en = 1'b0;
    tick();
    chk_a("hold", 5'b00010, 3'd1, 1'b0, 1'b0);

    // 2: down from state 0 wraps to N-1
    a_rb = 1'b1;
    tick();
    a_rb = 1'b0; a_en = 1'b1; a_inc = 1'b0;
    tick();
    chk_a("dn_wrap", 5'b10000, 3'd4, 1'b1, 1'b0);
    tick();
    chk_a("dn_step", 5'b01000, 3'd3, 1'b0, 1'b0);
    a_en = 1'b0;

    // 3: load wins over enable; out-of-range load recovers to state 0
    a_load = 1'b1; a_load_idx = 3'd3; a_en = 1'b1; a_inc = 1'b1;
    tick();
    chk_a("load3", 5'b01000, 3'd3, 1'b0, 1'b0);
    a_load_idx = 3'd6;
    tick();
    chk_a("load6", 5'b00001, 3'd0, 1'b0, 1'b1);
    a_load = 1'b0; a_en = 1'b0;
    tick();
    chk_a("load6_after", 5'b00001, 3'd0, 1'b0, 1'b0);

    // 4: illegal register contents recover, ignoring load and en
    a_load = 1'b1; a_load_idx = 3'd2; a_en = 1'b1; a_inc = 1'b1;
    force u_d5.cnt_q = 5'b00110;
    #1;
    release u_d5.cnt_q;
    tick();
    chk_a("illegal_rec", 5'b00001, 3'd0, 1'b0, 1'b1);
    a_load = 1'b0;
    tick();
    chk_a("illegal_next", 5'b00010, 3'd1, 1'b0, 1'b0);
    a_en = 1'b0;
    force u_d5.cnt_q = 5'b00000;
    #1;
    release u_d5.cnt_q;
    tick();
    chk_a("zero_rec", 5'b00001, 3'd0, 1'b0, 1'b1);
    tick();
    chk_a("zero_after", 5'b00001, 3'd0, 1'b0, 1'b0);

    // 5: saturating instance holds at the end stops
    s_en = 1'b1; s_inc = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk_s($sformatf("sat_up%0d", k), t5_cnt[k], t5_idx[k], 1'b0, t5_sat[k]);
    end
    s_inc = 1'b0;
    tick();
    chk_s("sat_dn1", 5'b01000, 3'd3, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk_s("sat_dn4", 5'b00001, 3'd0, 1'b0, 1'b1);
    tick();
    chk_s("sat_dn_hold", 5'b00001, 3'd0, 1'b0, 1'b1);
    s_en = 1'b0;

    // 6: reset overrides load and en in the same cycle
    a_load = 1'b1; a_load_idx = 3'd2;
    tick();
    chk_a("pre_rst_load", 5'b00100, 3'd2, 1'b0, 1'b0);
    a_rb = 1'b1; a_load_idx = 3'd6; a_en = 1'b1;
    tick();
    chk_a("rst_over", 5'b00001, 3'd0, 1'b0, 1'b0);
    check("rst_over.sat", 32'(a_sat), 32'd0);
    a_rb = 1'b0; a_load = 1'b0; a_en = 1'b0;

    // 6: N=2 toggles both directions
    b_en = 1'b1; b_inc = 1'b1;
    tick();
    chk_b("n2_up1", 2'b10, 1'b1, 1'b0);
    tick();
    chk_b("n2_up2", 2'b01, 1'b0, 1'b1);
    tick();
    chk_b("n2_up3", 2'b10, 1'b1, 1'b0);
    b_inc = 1'b0;
    tick();
    chk_b("n2_dn1", 2'b01, 1'b0, 1'b0);
    tick();
    chk_b("n2_dn2", 2'b10, 1'b1, 1'b1);
    b_en = 1'b0; b_load = 1'b1; b_load_idx = 1'b0;
    tick();
    chk_b("n2_load0", 2'b01, 1'b0, 1'b0);
    check("n2_load0.err", 32'(b_err), 32'd0);
    b_load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
